// File: rtl/spi_mem_target.sv
// SPI mode-0 target giving an external host byte access to an internal memory; all pins oversampled on clk.
// Optional write command (0x02) is compiled in with `define SPI_MEM_TARGET_WRITE_EN.
module spi_mem_target #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              cmd_err
);

`ifdef SPI_MEM_TARGET_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    // IDLE wait CS | CMD opcode | ADDR_HI/ADDR_LO address | RD_DATA/WR_DATA stream | IGNORE until CS high
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_RD_DATA, S_WR_DATA, S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx;
    logic [7:0]             r_tx;
    logic [7:0]             r_addr_hi;
    logic                   r_is_write;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic                   r_rd_en;
    logic                   r_rd_pend;
    logic                   r_wr_en;
    logic [7:0]             r_wdata;
    logic                   r_miso;
    logic                   r_miso_oe;
    logic                   r_busy;
    logic                   r_cmd_err;

    logic        w_cs_n;
    logic        w_rise;
    logic        w_fall;
    logic        w_mosi;
    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic        w_cmd_ok;
    logic [15:0] w_addr_full;

    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_rise      = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_fall      = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_cmd_ok    = (w_byte == 8'h03) || (WRITE_EN && (w_byte == 8'h02));
    assign w_addr_full = {r_addr_hi, w_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_n) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_CMD;
                S_CMD:     if (w_byte_done) w_state_nxt = w_cmd_ok ? S_ADDR_HI : S_IGNORE;
                S_ADDR_HI: if (w_byte_done) w_state_nxt = S_ADDR_LO;
                S_ADDR_LO: if (w_byte_done) w_state_nxt = r_is_write ? S_WR_DATA : S_RD_DATA;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr_hi   <= '0;
            r_is_write  <= 1'b0;
            r_mem_addr  <= '0;
            r_rd_en     <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wdata     <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_pend   <= r_rd_en;
            if (r_rd_pend) r_tx <= mem_rdata;
            // a completed write advances the address even if CS drops right after it
            if (r_wr_en) r_mem_addr <= r_mem_addr + ADDR_W'(1);
            if (w_cs_n) begin
                r_busy    <= 1'b0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
                r_bit_cnt <= '0;
            end else if (r_state == S_IDLE) begin
                r_busy    <= 1'b1;
                r_cmd_err <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                if (w_rise) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_is_write <= WRITE_EN && (w_byte == 8'h02);
                            if (!w_cmd_ok) r_cmd_err <= 1'b1;
                        end
                        S_ADDR_HI: r_addr_hi <= w_byte;
                        S_ADDR_LO: begin
                            r_mem_addr <= w_addr_full[ADDR_W-1:0];
                            r_rd_en    <= !r_is_write;
                        end
                        S_RD_DATA: begin
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                            r_rd_en    <= 1'b1;
                        end
                        S_WR_DATA: begin
                            r_wdata <= w_byte;
                            r_wr_en <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (w_fall && (r_state == S_RD_DATA)) begin
                    r_miso    <= r_tx[7];
                    r_tx      <= {r_tx[6:0], 1'b0};
                    r_miso_oe <= 1'b1;
                end
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign mem_addr    = r_mem_addr;
    assign mem_rd_en   = r_rd_en;
    assign mem_wr_en   = WRITE_EN & r_wr_en;
    assign mem_wdata   = WRITE_EN ? r_wdata : 8'h00;
    assign busy        = r_busy;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_spi_mem_target.sv
// Bench for spi_mem_target: bit-level SPI host, behavioural memory and per-scenario checks against an address/data model.
module tb_spi_mem_target;
    localparam int SYNC = 2;
`ifdef SPI_MEM_TARGET_WRITE_EN
    localparam bit WR_ON = 1'b1;
`else
    localparam bit WR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs, spi_sclk, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [15:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;
    logic        busy, cmd_err;

    int errors = 0;
    int checks = 0;
    int g_half = 6;

    logic [7:0]  mem [0:65535];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [15:0] rd_q [$];
    logic [23:0] wr_q [$];
    bit          both_seen;
    bit          oe_seen;

    spi_mem_target #(.SYNC_STAGES(SYNC), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (mem_wr_en) wr_q.push_back({mem_addr, mem_wdata});
        if (mem_rd_en && mem_wr_en) both_seen = 1'b1;
        if (spi_miso_oe) oe_seen = 1'b1;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        wr_q.delete();
        both_seen = 1'b0;
        oe_seen   = 1'b0;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        clks(g_half);
        r = spi_miso;
        spi_sclk = 1'b1;
        clks(g_half);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        clks(g_half);
    endtask

    task automatic cs_high();
        clks(g_half);
        spi_cs = 1'b1;
        clks(SYNC + 4);
    endtask

    task automatic run_txn();
        logic [7:0] r;
        rx_q.delete();
        cs_low();
        foreach (tx_q[i]) begin
            spi_byte(tx_q[i], r);
            rx_q.push_back(r);
        end
        cs_high();
    endtask

    task automatic check_read(input logic [15:0] addr, input int n);
        logic [15:0] a;
        tx_q.delete();
        tx_q.push_back(8'h03);
        tx_q.push_back(addr[15:8]);
        tx_q.push_back(addr[7:0]);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        clear_mon();
        run_txn();
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            checks++;
            if (rx_q[3+i] !== mem[a]) begin
                errors++;
                $display("FAIL read_data addr=%h got=%h exp=%h", a, rx_q[3+i], mem[a]);
            end
        end
        checks++;
        if (rd_q.size() != n + 1) begin
            errors++;
            $display("FAIL rd_strobe_count got=%0d exp=%0d", rd_q.size(), n + 1);
        end else begin
            for (int i = 0; i <= n; i++) begin
                checks++;
                if (rd_q[i] !== addr + 16'(i)) begin
                    errors++;
                    $display("FAIL rd_strobe_addr idx=%0d got=%h exp=%h", i, rd_q[i], addr + 16'(i));
                end
            end
        end
        checks++;
        if (oe_seen !== 1'b1 || both_seen !== 1'b0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL read_side oe_seen=%0b both=%0b writes=%0d exp 1 0 0", oe_seen, both_seen, wr_q.size());
        end
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL read_cmd_err got=%b exp=0", cmd_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(3);
        checks++;
        if ({spi_miso, spi_miso_oe, mem_rd_en, mem_wr_en, busy, cmd_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000", {spi_miso, spi_miso_oe, mem_rd_en, mem_wr_en, busy, cmd_err});
        end
        checks++;
        if (mem_addr !== 16'h0 || mem_wdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_addr_data got=%h/%h exp=0000/00", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_read_burst();
        mem[16'h0120] = 8'hA5; mem[16'h0121] = 8'h3C; mem[16'h0122] = 8'hFF;
        g_half = 6;
        check_read(16'h0120, 3);
        checks++;
        if ({rx_q[3], rx_q[4], rx_q[5]} !== 24'hA53CFF) begin
            errors++;
            $display("FAIL burst_bytes got=%h%h%h exp=A53CFF", rx_q[3], rx_q[4], rx_q[5]);
        end
    endtask

    task automatic test_wrap();
        check_read(16'hFFFF, 2);
    endtask

    task automatic test_random_reads();
        for (int k = 0; k < 6; k++) begin
            g_half = $urandom_range(5, 8);
            check_read(16'($urandom), $urandom_range(1, 4));
        end
        g_half = 6;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        cs_low();
        spi_byte(8'h03, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r[0]);
        rst = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || cmd_err !== 1'b0 || spi_miso_oe !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flags busy=%b err=%b oe=%b rd=%b exp 0", busy, cmd_err, spi_miso_oe, mem_rd_en);
        end
        checks++;
        if (mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_addr got=%h exp=0000", mem_addr);
        end
        spi_cs = 1'b1; spi_sclk = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(3);
        check_read(16'($urandom), 2);
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] c;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) c = 8'h9F;
            else begin
                c = 8'($urandom);
                while (c == 8'h03 || (WR_ON && c == 8'h02)) c = 8'($urandom);
            end
            tx_q.delete();
            tx_q.push_back(c);
            for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
            clear_mon();
            run_txn();
            checks++;
            if (cmd_err !== 1'b1) begin
                errors++;
                $display("FAIL unknown_cmd_err cmd=%h got=%b exp=1", c, cmd_err);
            end
            checks++;
            if (oe_seen !== 1'b0 || rd_q.size() != 0 || wr_q.size() != 0) begin
                errors++;
                $display("FAIL unknown_quiet cmd=%h oe=%0b rd=%0d wr=%0d exp 0 0 0", c, oe_seen, rd_q.size(), wr_q.size());
            end
            spi_cs = 1'b0;
            clks(SYNC + 3);
            checks++;
            if (cmd_err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL err_clear_on_cs err=%b busy=%b exp 0 1", cmd_err, busy);
            end
            spi_cs = 1'b1;
            clks(SYNC + 4);
        end
    endtask

    task automatic test_write();
        tx_q.delete();
        tx_q.push_back(8'h02); tx_q.push_back(8'h00); tx_q.push_back(8'h10);
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        clear_mon();
        run_txn();
        if (WR_ON) begin
            checks++;
            if (wr_q.size() != 2) begin
                errors++;
                $display("FAIL write_count got=%0d exp=2", wr_q.size());
            end else begin
                checks++;
                if (wr_q[0] !== 24'h001011 || wr_q[1] !== 24'h001122) begin
                    errors++;
                    $display("FAIL write_addr_data got=%h,%h exp=001011,001122", wr_q[0], wr_q[1]);
                end
            end
            checks++;
            if (cmd_err !== 1'b0 || rd_q.size() != 0 || oe_seen !== 1'b0) begin
                errors++;
                $display("FAIL write_side err=%b rd=%0d oe=%0b exp 0 0 0", cmd_err, rd_q.size(), oe_seen);
            end
            check_read(16'h0010, 2);
            checks++;
            if ({rx_q[3], rx_q[4]} !== 16'h1122) begin
                errors++;
                $display("FAIL write_readback got=%h%h exp=1122", rx_q[3], rx_q[4]);
            end
        end else begin
            checks++;
            if (cmd_err !== 1'b1 || wr_q.size() != 0 || rd_q.size() != 0) begin
                errors++;
                $display("FAIL write_disabled err=%b wr=%0d rd=%0d exp 1 0 0", cmd_err, wr_q.size(), rd_q.size());
            end
        end
    endtask

    task automatic abort_after(input logic [7:0] cmd, input logic [15:0] addr, input int exp_rd);
        logic [7:0] r;
        int n;
        clear_mon();
        cs_low();
        spi_byte(cmd, r);
        spi_byte(addr[15:8], r);
        spi_byte(addr[7:0], r);
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom), r[0]);
        spi_cs = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < SYNC + 3) begin
            clks(1);
            n++;
        end
        checks++;
        if (n > SYNC + 1) begin
            errors++;
            $display("FAIL abort_busy_drop cmd=%h clks=%0d exp<=%0d", cmd, n, SYNC + 1);
        end
        clks(4);
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != exp_rd || spi_miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobes cmd=%h wr=%0d rd=%0d oe=%b exp 0 %0d 0", cmd, wr_q.size(), rd_q.size(), spi_miso_oe, exp_rd);
        end
        checks++;
        if (mem_addr !== addr) begin
            errors++;
            $display("FAIL abort_addr_hold got=%h exp=%h", mem_addr, addr);
        end
    endtask

    task automatic test_abort();
        abort_after(8'h03, 16'($urandom), 1);
        if (WR_ON) abort_after(8'h02, 16'h0040, 0);
    endtask

    task automatic test_cs_vs_rise();
        logic [7:0] r;
        logic [15:0] prev;
        prev = mem_addr;
        clear_mon();
        cs_low();
        spi_byte(8'h03, r);
        spi_byte(8'h5A, r);
        for (int i = 0; i < 7; i++) spi_bit(1'($urandom), r[0]);
        spi_mosi = 1'b1;
        clks(g_half);
        spi_cs = 1'b1;
        clks(1);
        spi_sclk = 1'b1;
        clks(g_half);
        spi_sclk = 1'b0;
        clks(SYNC + 4);
        checks++;
        if (rd_q.size() != 0 || mem_addr !== prev || busy !== 1'b0) begin
            errors++;
            $display("FAIL cs_wins rd=%0d addr=%h busy=%b exp 0 %h 0", rd_q.size(), mem_addr, busy, prev);
        end
        check_read(16'($urandom), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        clear_mon();
        test_reset();
        test_read_burst();
        test_wrap();
        test_random_reads();
        test_reset_mid();
        test_unknown_cmd();
        test_write();
        test_abort();
        test_cs_vs_rise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
